// File: rtl/exc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// exc_ctrl_pkg
// Shared CP0 constants for the exception controller: register numbers,
// SR/Cause field positions, exception codes, the controller state type and
// the EPC computation helper.
// -----------------------------------------------------------------------------
package exc_ctrl_pkg;

   // CP0 register numbers
   localparam logic [4:0] CP0_COUNT   = 5'd9;
   localparam logic [4:0] CP0_COMPARE = 5'd11;
   localparam logic [4:0] CP0_SR      = 5'd12;
   localparam logic [4:0] CP0_CAUSE   = 5'd13;
   localparam logic [4:0] CP0_EPC     = 5'd14;
   localparam logic [4:0] CP0_PRID    = 5'd15;

   // SR field positions
   localparam int unsigned SR_IE    = 0;
   localparam int unsigned SR_EXL   = 1;
   localparam int unsigned SR_IM_LO = 10;

   // Cause field positions
   localparam int unsigned CAUSE_EXC_LO = 2;
   localparam int unsigned CAUSE_IP_LO  = 10;
   localparam int unsigned CAUSE_BD     = 31;

   // Exception codes
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;

   typedef enum logic {StRun, StHandler} exc_state_e;

   // Restart address: a delay-slot instruction restarts at its branch.
   function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
      logic [31:0] w_addr;
      w_addr = bd ? (pc - 32'd4) : pc;
      return {w_addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/exc_ctrl_timer.sv
// -----------------------------------------------------------------------------
// exc_ctrl_timer
// Count/Compare timer for the exception controller (used only when
// EXC_CTRL_TIMER_EN is defined).
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_count_we           load Count from i_wdata
//   i_compare_we         load Compare from i_wdata, clears pending
//   i_wdata              write data
//   o_count, o_compare   register values
//   o_pending            sticky timer interrupt request
// -----------------------------------------------------------------------------
module exc_ctrl_timer
   import exc_ctrl_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_count_we,
   input  logic        i_compare_we,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_count,
   output logic [31:0] o_compare,
   output logic        o_pending
);

   logic [31:0] r_count;
   logic [31:0] r_compare;
   logic        r_pending;
   logic [31:0] w_count_next;

   assign w_count_next = i_count_we ? i_wdata : (r_count + 32'd1);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count   <= '0;
         r_compare <= '0;
         r_pending <= 1'b0;
      end else begin
         r_count <= w_count_next;
         if (i_compare_we) begin
            r_compare <= i_wdata;
            r_pending <= 1'b0;
         // Match on the value Count takes next, so pending is visible in the
         // cycle Count equals Compare and 0==0 is not hit straight out of reset.
         end else if (w_count_next == r_compare) begin
            r_pending <= 1'b1;
         end
      end
   end

   assign o_count   = r_count;
   assign o_compare = r_compare;
   assign o_pending = r_pending;

endmodule

// File: rtl/exc_ctrl.sv
// -----------------------------------------------------------------------------
// exc_ctrl
// CP0-style exception/interrupt controller. Holds SR, Cause, EPC, PRId,
// arbitrates M-stage exceptions against hardware interrupts and drives the
// PC handler-redirect (o_exc_handle) and return (o_eret) controls.
// Optional macro EXC_CTRL_TIMER_EN adds Count (reg 9) / Compare (reg 11) with a
// timer interrupt ORed into the top hardware interrupt line.
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_cp0_addr/we/wdata    mtc0 access; o_cp0_rdata mfc0 read (combinational)
//   i_pc_m, i_bd_m         M-stage PC and branch-delay flag
//   i_exc_occur_m/code_m   M-stage synchronous exception and its code
//   i_eret_m               eret in M
//   i_hw_int               level-sensitive interrupt lines
//   o_exc_handle           redirect to handler, flush F/D/E/M
//   o_eret                 redirect to EPC
//   o_epc                  current EPC
// -----------------------------------------------------------------------------
module exc_ctrl
   import exc_ctrl_pkg::*;
#(
   parameter logic [31:0] PRID = 32'h4254_4150,
   parameter int unsigned IM_W = 6
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic [4:0]      i_cp0_addr,
   input  logic            i_cp0_we,
   input  logic [31:0]     i_cp0_wdata,
   output logic [31:0]     o_cp0_rdata,
   input  logic [31:0]     i_pc_m,
   input  logic            i_bd_m,
   input  logic            i_exc_occur_m,
   input  logic [4:0]      i_exc_code_m,
   input  logic            i_eret_m,
   input  logic [IM_W-1:0] i_hw_int,
   output logic            o_exc_handle,
   output logic            o_eret,
   output logic [31:0]     o_epc
);

   exc_state_e      r_state;
   exc_state_e      w_state_next;
   logic [IM_W-1:0] r_sr_im;
   logic            r_sr_ie;
   logic            r_cause_bd;
   logic [IM_W-1:0] r_cause_ip;
   logic [4:0]      r_cause_code;
   logic [31:0]     r_epc;

   logic            w_exl;
   logic [IM_W-1:0] w_hw_int;
   logic            w_int_req;
   logic            w_exc_req;
   logic            w_exc_handle;
   logic            w_eret;
   logic            w_we;
   logic [31:0]     w_sr;
   logic [31:0]     w_cause;

   // EXL is the state itself, so the two can never disagree.
   assign w_exl = (r_state == StHandler);

`ifdef EXC_CTRL_TIMER_EN
   logic [31:0] w_tmr_count;
   logic [31:0] w_tmr_compare;
   logic        w_tmr_pending;

   exc_ctrl_timer u_timer (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_count_we   (w_we && (i_cp0_addr == CP0_COUNT)),
      .i_compare_we (w_we && (i_cp0_addr == CP0_COMPARE)),
      .i_wdata      (i_cp0_wdata),
      .o_count      (w_tmr_count),
      .o_compare    (w_tmr_compare),
      .o_pending    (w_tmr_pending)
   );

   assign w_hw_int = i_hw_int | {w_tmr_pending, {(IM_W-1){1'b0}}};
`else
   assign w_hw_int = i_hw_int;
`endif

   assign w_int_req    = r_sr_ie & ~w_exl & (|(w_hw_int & r_sr_im));
   assign w_exc_req    = i_exc_occur_m & ~w_exl;
   assign w_exc_handle = w_int_req | w_exc_req;
   assign w_eret       = i_eret_m & w_exl;
   // An mtc0 in the same cycle as a redirect is flushed with its instruction.
   assign w_we         = i_cp0_we & ~w_exc_handle;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= StRun;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      if (w_exc_handle) begin
         w_state_next = StHandler;
      end else if (w_eret) begin
         w_state_next = StRun;
      end else if (w_we && (i_cp0_addr == CP0_SR)) begin
         w_state_next = i_cp0_wdata[SR_EXL] ? StHandler : StRun;
      end
   end

   // Outputs
   always_comb begin
      o_exc_handle = w_exc_handle;
      o_eret       = w_eret;
      o_epc        = r_epc;
   end

   // CP0 data registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sr_im      <= '0;
         r_sr_ie      <= 1'b0;
         r_cause_bd   <= 1'b0;
         r_cause_ip   <= '0;
         r_cause_code <= '0;
         r_epc        <= '0;
      end else begin
         r_cause_ip <= w_hw_int;
         if (w_exc_handle) begin
            r_cause_bd   <= i_bd_m;
            r_cause_code <= w_int_req ? EXC_INT : i_exc_code_m;
            r_epc        <= epc_of(i_pc_m, i_bd_m);
         end else if (w_we) begin
            if (i_cp0_addr == CP0_SR) begin
               r_sr_im <= i_cp0_wdata[SR_IM_LO +: IM_W];
               r_sr_ie <= i_cp0_wdata[SR_IE];
            end else if (i_cp0_addr == CP0_EPC) begin
               r_epc <= i_cp0_wdata;
            end
         end
      end
   end

   always_comb begin
      w_sr                      = '0;
      w_sr[SR_IM_LO +: IM_W]    = r_sr_im;
      w_sr[SR_EXL]              = w_exl;
      w_sr[SR_IE]               = r_sr_ie;
      w_cause                   = '0;
      w_cause[CAUSE_BD]         = r_cause_bd;
      w_cause[CAUSE_IP_LO +: IM_W] = r_cause_ip;
      w_cause[CAUSE_EXC_LO +: 5] = r_cause_code;
   end

   // mfc0 read mux
   always_comb begin
      o_cp0_rdata = '0;
      case (i_cp0_addr)
         CP0_SR:      o_cp0_rdata = w_sr;
         CP0_CAUSE:   o_cp0_rdata = w_cause;
         CP0_EPC:     o_cp0_rdata = r_epc;
         CP0_PRID:    o_cp0_rdata = PRID;
`ifdef EXC_CTRL_TIMER_EN
         CP0_COUNT:   o_cp0_rdata = w_tmr_count;
         CP0_COMPARE: o_cp0_rdata = w_tmr_compare;
`endif
         default:     o_cp0_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_exc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exc_ctrl
// Scoreboard bench for exc_ctrl: stimulus pushes the expected value of one
// observable for the current cycle; a monitor pops and compares at negedge.
// -----------------------------------------------------------------------------
module tb_exc_ctrl;

   localparam logic [31:0] PRID = 32'h4254_4150;
   localparam int SEL_RD   = 0;
   localparam int SEL_EH   = 1;
   localparam int SEL_ER   = 2;
   localparam int SEL_EPCO = 3;

   logic        clk;
   logic        reset;
   logic [4:0]  cp0_addr;
   logic        cp0_we;
   logic [31:0] cp0_wdata;
   logic [31:0] cp0_rdata;
   logic [31:0] pc_m;
   logic        bd_m;
   logic        exc_occur_m;
   logic [4:0]  exc_code_m;
   logic        eret_m;
   logic [5:0]  hw_int;
   logic        exc_handle;
   logic        eret;
   logic [31:0] epc;

   typedef struct {
      int          cyc;
      int          sel;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   exc_ctrl #(
      .PRID (PRID),
      .IM_W (6)
   ) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_cp0_addr    (cp0_addr),
      .i_cp0_we      (cp0_we),
      .i_cp0_wdata   (cp0_wdata),
      .o_cp0_rdata   (cp0_rdata),
      .i_pc_m        (pc_m),
      .i_bd_m        (bd_m),
      .i_exc_occur_m (exc_occur_m),
      .i_exc_code_m  (exc_code_m),
      .i_eret_m      (eret_m),
      .i_hw_int      (hw_int),
      .o_exc_handle  (exc_handle),
      .o_eret        (eret),
      .o_epc         (epc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation queued for this cycle.
   always @(negedge clk) begin : monitor
      exp_t        e;
      logic [31:0] act;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         case (e.sel)
            SEL_RD:   act = cp0_rdata;
            SEL_EH:   act = {31'd0, exc_handle};
            SEL_ER:   act = {31'd0, eret};
            default:  act = epc;
         endcase
         n_checks = n_checks + 1;
         if (act !== e.val || e.cyc != cyc) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", e.name, act, e.val, cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input int sel, input logic [31:0] v, input string n);
      exp_t e;
      e.cyc  = cyc;
      e.sel  = sel;
      e.val  = v;
      e.name = n;
      q.push_back(e);
   endtask

   task automatic cp0(input logic [4:0] a, input logic we, input logic [31:0] d);
      cp0_addr  = a;
      cp0_we    = we;
      cp0_wdata = d;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      cp0(5'd0, 1'b0, 32'd0);
      pc_m = '0; bd_m = 1'b0; exc_occur_m = 1'b0; exc_code_m = '0;
      eret_m = 1'b0; hw_int = '0;
      step(); step();
      reset = 1'b0;

      // Reset values
      cp0(5'd12, 1'b0, 32'd0);
      chk(SEL_RD, 32'd0, "sr_rst"); chk(SEL_EH, 32'd0, "eh_rst");
      chk(SEL_ER, 32'd0, "eret_rst"); chk(SEL_EPCO, 32'd0, "epc_rst");
      step();
      cp0(5'd13, 1'b0, 32'd0); chk(SEL_RD, 32'd0, "cause_rst"); step();
      cp0(5'd14, 1'b0, 32'd0); chk(SEL_RD, 32'd0, "epc_reg_rst"); step();
      cp0(5'd15, 1'b0, 32'd0); chk(SEL_RD, PRID, "prid"); step();

`ifndef EXC_CTRL_TIMER_EN
      // Timer registers absent: writes ignored, reads zero
      cp0(5'd9, 1'b1, 32'h0000_ffff); step();
      cp0(5'd11, 1'b1, 32'h0000_0007); step();
      cp0(5'd9, 1'b0, 32'd0); chk(SEL_RD, 32'd0, "count_absent"); step();
      cp0(5'd11, 1'b0, 32'd0); chk(SEL_RD, 32'd0, "compare_absent"); step();
`endif

      // Interrupt entry
      cp0(5'd12, 1'b1, 32'h0000_0401); chk(SEL_EH, 32'd0, "sr_wr_no_eh"); step();
      cp0(5'd12, 1'b0, 32'd0); hw_int = 6'd1; pc_m = 32'h3010;
      chk(SEL_RD, 32'h401, "sr_wr"); chk(SEL_EH, 32'd1, "int_eh"); step();
      pc_m = '0;
      cp0(5'd14, 1'b0, 32'd0);
      chk(SEL_RD, 32'h3010, "int_epc"); chk(SEL_EH, 32'd0, "int_masked_exl"); step();
      cp0(5'd13, 1'b0, 32'd0); chk(SEL_RD, 32'h400, "int_cause"); step();
      hw_int = '0; eret_m = 1'b1;
      cp0(5'd12, 1'b0, 32'd0); chk(SEL_RD, 32'h403, "int_sr_exl");
      chk(SEL_ER, 32'd1, "eret_int"); chk(SEL_EPCO, 32'h3010, "eret_int_epc"); step();
      eret_m = 1'b0; chk(SEL_RD, 32'h401, "eret_exl_clr"); step();

      // Delay-slot AdEL exception
      exc_occur_m = 1'b1; exc_code_m = 5'd4; bd_m = 1'b1; pc_m = 32'h3024;
      chk(SEL_EH, 32'd1, "adel_eh"); step();
      exc_occur_m = 1'b0; bd_m = 1'b0; pc_m = '0;
      cp0(5'd14, 1'b0, 32'd0); chk(SEL_RD, 32'h3020, "adel_epc"); step();
      exc_occur_m = 1'b1;
      cp0(5'd13, 1'b0, 32'd0); chk(SEL_RD, 32'h8000_0010, "adel_cause");
      chk(SEL_EH, 32'd0, "exc_masked_exl"); step();
      exc_occur_m = 1'b0; eret_m = 1'b1;
      chk(SEL_ER, 32'd1, "eret_adel"); chk(SEL_EPCO, 32'h3020, "eret_adel_epc"); step();
      cp0(5'd12, 1'b0, 32'd0); chk(SEL_RD, 32'h401, "eret_adel_exl");
      chk(SEL_ER, 32'd0, "eret_no_exl"); chk(SEL_EH, 32'd0, "eret_no_exl_eh"); step();
      eret_m = 1'b0;

      // mtc0 EPC then eret next cycle uses the new EPC
      cp0(5'd12, 1'b1, 32'h0000_0403); step();
      cp0(5'd14, 1'b1, 32'h0000_4000); step();
      cp0(5'd12, 1'b0, 32'd0); eret_m = 1'b1;
      chk(SEL_ER, 32'd1, "eret_new_epc"); chk(SEL_EPCO, 32'h4000, "eret_new_epc_val"); step();
      eret_m = 1'b0; chk(SEL_RD, 32'h401, "eret_new_epc_exl"); step();

      // Interrupt + exception + mtc0 EPC together
      hw_int = 6'd1; exc_occur_m = 1'b1; exc_code_m = 5'd4; pc_m = 32'h5008;
      cp0(5'd14, 1'b1, 32'hdead_0000); chk(SEL_EH, 32'd1, "both_eh"); step();
      hw_int = '0; exc_occur_m = 1'b0; pc_m = '0;
      cp0(5'd13, 1'b0, 32'd0); chk(SEL_RD, 32'h400, "both_cause"); step();
      cp0(5'd14, 1'b0, 32'd0); chk(SEL_RD, 32'h5008, "both_epc_kept"); step();

      // mtc0 SR clearing EXL leaves the handler
      cp0(5'd12, 1'b1, 32'd0); step();
      cp0(5'd12, 1'b0, 32'd0); chk(SEL_RD, 32'd0, "sr_force_run"); step();

      // PC_M-4 wraps modulo 2^32
      exc_occur_m = 1'b1; exc_code_m = 5'd10; bd_m = 1'b1; pc_m = 32'h0000_0002;
      chk(SEL_EH, 32'd1, "wrap_eh"); step();
      exc_occur_m = 1'b0; bd_m = 1'b0; pc_m = '0;
      cp0(5'd14, 1'b0, 32'd0); chk(SEL_RD, 32'hffff_fffc, "wrap_epc"); step();
      cp0(5'd13, 1'b0, 32'd0); chk(SEL_RD, 32'h8000_0028, "wrap_cause"); step();

      // Reset while in the handler
      reset = 1'b1; step();
      reset = 1'b0; eret_m = 1'b1;
      cp0(5'd12, 1'b0, 32'd0); chk(SEL_RD, 32'd0, "rst_mid_sr");
      chk(SEL_ER, 32'd0, "rst_mid_eret"); chk(SEL_EPCO, 32'd0, "rst_mid_epc"); step();
      eret_m = 1'b0;

`ifdef EXC_CTRL_TIMER_EN
      // Timer interrupt at Count==Compare==5
      cp0(5'd9, 1'b1, 32'd0); step();
      cp0(5'd11, 1'b1, 32'd5); step();
      cp0(5'd12, 1'b1, 32'h0000_8001); step();
      cp0(5'd12, 1'b0, 32'd0); chk(SEL_EH, 32'd0, "tmr_eh_c2"); step();
      cp0(5'd9, 1'b0, 32'd0); chk(SEL_RD, 32'd3, "tmr_count");
      chk(SEL_EH, 32'd0, "tmr_eh_c3"); step();
      chk(SEL_EH, 32'd0, "tmr_eh_c4"); step();
      chk(SEL_EH, 32'd1, "tmr_eh"); step();
      cp0(5'd11, 1'b1, 32'd100); step();
      cp0(5'd13, 1'b0, 32'd0); chk(SEL_RD, 32'h0000_8000, "tmr_ip"); step();
      chk(SEL_RD, 32'd0, "tmr_ip_clr"); step();
      cp0(5'd12, 1'b1, 32'h0000_8001); step();
      cp0(5'd12, 1'b0, 32'd0); chk(SEL_EH, 32'd0, "tmr_pend_clr"); step();
`endif

      step(); step();
      if (q.size() != 0) begin
         n_fail = n_fail + 1;
         $display("FAIL scoreboard_drain: actual=%0d left required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
